// File: rtl/dnaport_pkg.sv
// Shared definitions for the device-DNA readout wrapper.
// Covers the DNA width, the counter width and the sequencer state encoding.
package dnaport_pkg;

    localparam int DNA_WIDTH = 96;
    localparam int CNT_WIDTH = 7;

    // The last shift happens when the counter holds this value.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DNA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } dna_state_t;

endpackage

// File: rtl/dnaport_model.sv
// Device DNA port: the DNA_PORTE2 primitive in synthesis, and a behavioural
// 96-bit shift register preloaded from SIM_DNA in simulation.
module dnaport_model
    import dnaport_pkg::*;
#(
    parameter logic [DNA_WIDTH-1:0] SIM_DNA = 96'h0
) (
    input  logic i_clk,
    input  logic i_read,
    input  logic i_shift,
    input  logic i_din,
    output logic o_dout
);

`ifdef SYNTHESIS
    DNA_PORTE2 #(
        .SIM_DNA_VALUE (SIM_DNA)
    ) u_dna_port (
        .CLK   (i_clk),
        .READ  (i_read),
        .SHIFT (i_shift),
        .DIN   (i_din),
        .DOUT  (o_dout)
    );
`else
    logic [DNA_WIDTH-1:0] r_dna;

    // READ takes priority; the sequencer never raises both together anyway.
    always_ff @(posedge i_clk) begin
        if (i_read) begin
            r_dna <= SIM_DNA;
        end else if (i_shift) begin
            r_dna <= {i_din, r_dna[DNA_WIDTH-1:1]};
        end
    end

    assign o_dout = r_dna[0];
`endif

endmodule

// File: rtl/dnaport_wrap.sv
// Reads the device DNA once after reset and presents it on registered outputs.
// Sequence: one READ cycle, 96 SHIFT cycles, then the result is held until reset.
module dnaport_wrap
    import dnaport_pkg::*;
#(
    parameter logic [DNA_WIDTH-1:0] SIM_DNA = 96'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [DNA_WIDTH-1:0] dna_o,
    output logic                 dna_valid_o
);

    dna_state_t           r_state;
    dna_state_t           w_next;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [DNA_WIDTH-1:0] r_sr;
    logic [DNA_WIDTH-1:0] r_dna;
    logic                 r_valid;
    logic                 w_read;
    logic                 w_shift;
    logic                 w_dout;
    logic                 w_last;

    // Values at or beyond the last index also end the sequence, so a corrupted
    // counter can never keep SHIFT asserted.
    assign w_last = (r_cnt >= CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_dna   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                ST_READ: r_cnt <= '0;
                ST_SHIFT: begin
                    r_sr  <= {w_dout, r_sr[DNA_WIDTH-1:1]};
                    r_cnt <= r_cnt + CNT_WIDTH'(1);
                    if (w_last) begin
                        r_dna   <= {w_dout, r_sr[DNA_WIDTH-1:1]};
                        r_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Port strobes are gated with rst so a reset edge never moves the DNA port.
    always_comb begin
        w_next  = r_state;
        w_read  = 1'b0;
        w_shift = 1'b0;
        unique case (r_state)
            ST_IDLE: w_next = ST_READ;
            ST_READ: begin
                w_read = rst;
                w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shift = rst;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    dnaport_model #(
        .SIM_DNA (SIM_DNA)
    ) u_model (
        .i_clk   (clk),
        .i_read  (w_read),
        .i_shift (w_shift),
        .i_din   (1'b0),
        .o_dout  (w_dout)
    );

    assign dna_o       = r_dna;
    assign dna_valid_o = r_valid;

endmodule

// File: tb/tb_dnaport_wrap.sv
// Directed bench for dnaport_wrap: power-up readout, long reset hold,
// mid-shift abort, result stability and READ/SHIFT protocol monitoring.
module tb_dnaport_wrap;

    localparam logic [95:0] DNA_A = 96'h112233445566778899AABBCC;
    localparam logic [95:0] DNA_B = 96'h800000000000000000000001;

    logic        tb_rclk;
    logic        rst;
    logic [95:0] dnaA;
    logic        validA;
    logic [95:0] dnaB;
    logic        validB;

    int vectors     = 0;
    int miscompares = 0;

    int readCnt     = 0;
    int shiftCnt    = 0;
    int overlapCnt  = 0;
    int badInReset  = 0;

    dnaport_wrap #(.SIM_DNA(DNA_A)) dut (
        .clk         (tb_rclk),
        .rst         (rst),
        .dna_o       (dnaA),
        .dna_valid_o (validA)
    );

    dnaport_wrap #(.SIM_DNA(DNA_B)) dutB (
        .clk         (tb_rclk),
        .rst         (rst),
        .dna_o       (dnaB),
        .dna_valid_o (validB)
    );

    initial tb_rclk = 1'b0;
    always #5 tb_rclk = ~tb_rclk;

    // Strobe monitor: counts per sequence, restarting whenever reset is sampled.
    always @(posedge tb_rclk) begin
        if (!rst) begin
            readCnt  = 0;
            shiftCnt = 0;
            if (dut.w_read || dut.w_shift) badInReset++;
        end else begin
            if (dut.w_read)  readCnt++;
            if (dut.w_shift) shiftCnt++;
        end
        if (dut.w_read && dut.w_shift) overlapCnt++;
    end

    task automatic applyStimulus(input logic rstVal, input int nEdges);
        rst = rstVal;
        repeat (nEdges) @(posedge tb_rclk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [96:0] obs, input logic [96:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic okHold;
        logic okStrobe;

        rst = 1'b0;
        $display("[TB] power-up reset");
        applyStimulus(1'b0, 10);
        checkOutput("reset_dna", {1'b0, dnaA}, 97'h0);
        checkOutput("reset_valid", {96'h0, validA}, 97'h0);
        checkOutput("reset_strobes", {95'h0, dut.w_read, dut.w_shift}, 97'h0);

        $display("[TB] first readout");
        applyStimulus(1'b1, 50);
        checkOutput("midshift_dna", {1'b0, dnaA}, 97'h0);
        checkOutput("midshift_valid", {96'h0, validA}, 97'h0);
        applyStimulus(1'b1, 47);
        checkOutput("edge97_valid", {96'h0, validA}, 97'h0);
        checkOutput("edge97_dna", {1'b0, dnaA}, 97'h0);
        applyStimulus(1'b1, 1);
        checkOutput("edge98_valid", {96'h0, validA}, 97'h1);
        checkOutput("edge98_dna", {1'b0, dnaA}, {1'b0, DNA_A});
        checkOutput("bitorder_dna", {1'b0, dnaB}, {1'b0, DNA_B});
        checkOutput("bitorder_valid", {96'h0, validB}, 97'h1);
        checkOutput("read_count", 97'(readCnt), 97'd1);
        checkOutput("shift_count", 97'(shiftCnt), 97'd96);

        $display("[TB] hold after done");
        okHold = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            applyStimulus(1'b1, 1);
            if (dnaA !== DNA_A || validA !== 1'b1 || dut.w_read !== 1'b0 || dut.w_shift !== 1'b0)
                okHold = 1'b0;
        end
        checkOutput("done_stable", {96'h0, okHold}, 97'h1);
        checkOutput("done_counts", {1'b0, 48'(readCnt), 48'(shiftCnt)}, {1'b0, 48'd1, 48'd96});

        $display("[TB] long reset hold");
        applyStimulus(1'b0, 1);
        okHold = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (dnaA !== 96'h0 || validA !== 1'b0 || dnaB !== 96'h0 || validB !== 1'b0)
                okHold = 1'b0;
            applyStimulus(1'b0, 1);
        end
        checkOutput("hold_outputs_zero", {96'h0, okHold}, 97'h1);
        checkOutput("hold_no_strobes", 97'(badInReset), 97'd0);

        applyStimulus(1'b1, 97);
        checkOutput("rehold_edge97_valid", {96'h0, validA}, 97'h0);
        applyStimulus(1'b1, 1);
        checkOutput("rehold_edge98_valid", {96'h0, validA}, 97'h1);
        checkOutput("rehold_dna", {1'b0, dnaA}, {1'b0, DNA_A});

        $display("[TB] abort at shift cycle 40");
        applyStimulus(1'b0, 1);
        applyStimulus(1'b1, 42);
        checkOutput("preabort_valid", {96'h0, validA}, 97'h0);
        applyStimulus(1'b0, 1);
        checkOutput("abort_dna", {1'b0, dnaA}, 97'h0);
        checkOutput("abort_valid", {96'h0, validA}, 97'h0);
        okStrobe = 1'b1;
        for (int i = 0; i < 97; i++) begin
            applyStimulus(1'b1, 1);
            if (validA !== 1'b0 || dnaA !== 96'h0) okStrobe = 1'b0;
        end
        checkOutput("postabort_low", {96'h0, okStrobe}, 97'h1);
        applyStimulus(1'b1, 1);
        checkOutput("postabort_valid", {96'h0, validA}, 97'h1);
        checkOutput("postabort_dna", {1'b0, dnaA}, {1'b0, DNA_A});
        checkOutput("postabort_dnaB", {1'b0, dnaB}, {1'b0, DNA_B});
        checkOutput("postabort_counts", {1'b0, 48'(readCnt), 48'(shiftCnt)}, {1'b0, 48'd1, 48'd96});

        applyStimulus(1'b1, 20);
        checkOutput("no_overlap", 97'(overlapCnt), 97'd0);
        checkOutput("final_counts", {1'b0, 48'(readCnt), 48'(shiftCnt)}, {1'b0, 48'd1, 48'd96});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
